// File: rtl/multdiv_sequencer_pkg.sv
// rtl/multdiv_sequencer_pkg.sv - state encodings and default iteration constants for the multdiv sequencer
package multdiv_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } seq_state_t;

  localparam int DEFAULT_CNT_W      = 6;
  localparam int DEFAULT_MULT_ITERS = 16;
  localparam int DEFAULT_DIV_ITERS  = 32;

  function automatic bit iters_legal(input int iters, input int cnt_w);
    return (iters >= 1) && (iters < (1 << cnt_w));
  endfunction

endpackage

// File: rtl/multdiv_sequencer_down_counter_load.sv
// rtl/multdiv_sequencer_down_counter_load.sv - loadable down counter with borrow-chain decrement and zero/one flags
module down_counter_load #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             zero,
  output logic             one
);

  logic [CNT_W-1:0] dec_value;
  logic             borrow;

  assign zero = (count == '0);
  assign one  = (count == CNT_W'(1));

  // Bit i toggles when every lower bit is 0; gating with ~zero stops the count wrapping.
  always_comb begin
    dec_value = count;
    borrow    = en & ~zero;
    for (int i = 0; i < CNT_W; i++) begin
      dec_value[i] = count[i] ^ borrow;
      borrow       = borrow & ~count[i];
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else begin
      count <= dec_value;
    end
  end

endmodule

// File: rtl/multdiv_sequencer.sv
// rtl/multdiv_sequencer.sv - iteration sequencer issuing load/step strobes and result-ready for the multdiv unit
module multdiv_sequencer
  import multdiv_sequencer_pkg::*;
#(
  parameter int CNT_W      = DEFAULT_CNT_W,
  parameter int MULT_ITERS = DEFAULT_MULT_ITERS,
  parameter int DIV_ITERS  = DEFAULT_DIV_ITERS
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic             busy,
  output logic             op_is_div,
  output logic             load_operands,
  output logic             step_en,
  output logic             last_step,
  output logic [CNT_W-1:0] iter_count,
  output logic             data_resultRDY
);

  generate
    if (!iters_legal(MULT_ITERS, CNT_W)) begin : g_bad_mult
      $error("multdiv_sequencer: MULT_ITERS out of range for CNT_W");
    end
    if (!iters_legal(DIV_ITERS, CNT_W)) begin : g_bad_div
      $error("multdiv_sequencer: DIV_ITERS out of range for CNT_W");
    end
  endgenerate

  seq_state_t       state;
  logic             start;
  logic [CNT_W-1:0] start_iters;
  logic             cnt_zero;
  logic             cnt_one;

  assign start       = ctrl_MULT | ctrl_DIV;
  assign start_iters = ctrl_DIV ? CNT_W'(DIV_ITERS) : CNT_W'(MULT_ITERS);

  down_counter_load #(
    .CNT_W(CNT_W)
  ) u_counter (
    .clk       (clk),
    .clr       (clr),
    .load      (start),
    .load_value(start_iters),
    .en        (state == ST_RUN),
    .count     (iter_count),
    .zero      (cnt_zero),
    .one       (cnt_one)
  );

  // A new start in any state restarts the sequence, so an aborted op never reaches DONE.
  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= ST_IDLE;
      op_is_div <= 1'b0;
    end else if (start) begin
      state     <= ST_LOAD;
      op_is_div <= ctrl_DIV;
    end else begin
      unique case (state)
        ST_IDLE: state <= ST_IDLE;
        ST_LOAD: state <= ST_RUN;
        ST_RUN:  state <= (cnt_one || cnt_zero) ? ST_DONE : ST_RUN;
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy           = (state == ST_LOAD) || (state == ST_RUN);
  assign load_operands  = (state == ST_LOAD);
  assign step_en        = (state == ST_RUN);
  assign last_step      = (state == ST_RUN) && cnt_one;
  assign data_resultRDY = (state == ST_DONE);

endmodule

// File: tb/tb_multdiv_sequencer.sv
// tb/tb_multdiv_sequencer.sv - randomized and directed self-checking bench for multdiv_sequencer
module tb_multdiv_sequencer;

  localparam int CNT_W      = 6;
  localparam int MULT_ITERS = 16;
  localparam int DIV_ITERS  = 32;

  logic             clk;
  logic             clr;
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic             busy;
  logic             op_is_div;
  logic             load_operands;
  logic             step_en;
  logic             last_step;
  logic [CNT_W-1:0] iter_count;
  logic             data_resultRDY;

  multdiv_sequencer #(
    .CNT_W     (CNT_W),
    .MULT_ITERS(MULT_ITERS),
    .DIV_ITERS (DIV_ITERS)
  ) dut (
    .clk           (clk),
    .clr           (clr),
    .ctrl_MULT     (ctrl_MULT),
    .ctrl_DIV      (ctrl_DIV),
    .busy          (busy),
    .op_is_div     (op_is_div),
    .load_operands (load_operands),
    .step_en       (step_en),
    .last_step     (last_step),
    .iter_count    (iter_count),
    .data_resultRDY(data_resultRDY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_asserts = 0;
  int n_fails   = 0;
  int n_rdy     = 0;

  // Reference: cycles elapsed since the last accepted start, and that op's length.
  bit m_active = 0;
  int m_off    = 0;
  int m_n      = 0;
  bit m_div    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic m, input logic d, input logic c);
    int exp_iter;
    bit in_run;
    ctrl_MULT = m;
    ctrl_DIV  = d;
    clr       = c;
    @(posedge clk);
    if (c) begin
      m_active = 0;
      m_div    = 0;
    end else if (m || d) begin
      m_active = 1;
      m_off    = 1;
      m_n      = d ? DIV_ITERS : MULT_ITERS;
      m_div    = d;
    end else if (m_active) begin
      m_off++;
      if (m_off > m_n + 2) m_active = 0;
    end
    #1;
    in_run = m_active && (m_off >= 2) && (m_off <= m_n + 1);
    if (!m_active)        exp_iter = 0;
    else if (m_off == 1)  exp_iter = m_n;
    else if (in_run)      exp_iter = m_n - (m_off - 2);
    else                  exp_iter = 0;
    check("busy",           32'(busy),           32'(m_active && m_off <= m_n + 1));
    check("load_operands",  32'(load_operands),  32'(m_active && m_off == 1));
    check("step_en",        32'(step_en),        32'(in_run));
    check("last_step",      32'(last_step),      32'(m_active && m_off == m_n + 1));
    check("iter_count",     32'(iter_count),     32'(exp_iter));
    check("data_resultRDY", 32'(data_resultRDY), 32'(m_active && m_off == m_n + 2));
    check("op_is_div",      32'(op_is_div),      32'(m_div));
    if (data_resultRDY === 1'b1) n_rdy++;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    clr       = 1'b0;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int rdy_before;
    clr       = 1'b1;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;

    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    idle(3);

    // Multiply: result-ready 18 cycles after the start pulse.
    step(1'b1, 1'b0, 1'b0);
    rdy_before = n_rdy;
    idle(20);
    check("mult_rdy_count", 32'(n_rdy - rdy_before), 32'd1);

    // Divide: 32 iterations.
    step(1'b0, 1'b1, 1'b0);
    rdy_before = n_rdy;
    idle(36);
    check("div_rdy_count", 32'(n_rdy - rdy_before), 32'd1);

    // Multiply aborted by a divide at cycle 8.
    step(1'b1, 1'b0, 1'b0);
    idle(7);
    step(1'b0, 1'b1, 1'b0);
    rdy_before = n_rdy;
    idle(36);
    check("abort_rdy_count", 32'(n_rdy - rdy_before), 32'd1);

    // Both starts together: divide wins.
    step(1'b1, 1'b1, 1'b0);
    idle(36);

    // clr in the middle of a run, then a clean multiply.
    step(1'b1, 1'b0, 1'b0);
    idle(9);
    rdy_before = n_rdy;
    step(1'b0, 1'b0, 1'b1);
    idle(10);
    check("clr_no_rdy", 32'(n_rdy - rdy_before), 32'd0);
    step(1'b1, 1'b0, 1'b0);
    idle(19);

    // Start arriving exactly in the DONE cycle.
    step(1'b1, 1'b0, 1'b0);
    idle(17);
    step(1'b0, 1'b1, 1'b0);
    idle(36);

    // Random activity, with two cycles of clr inserted mid-stream.
    for (int i = 0; i < 600; i++) begin
      logic rm, rd, rc;
      rm = ($urandom_range(0, 29) == 0);
      rd = ($urandom_range(0, 39) == 0);
      rc = (i == 300 || i == 301) ? 1'b1 : ($urandom_range(0, 199) == 0);
      step(rm, rd, rc);
    end
    idle(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
